// File: rtl/clock_display_scan.sv
// clock_display_scan
//
// Time-multiplexed driver for a six-digit HH:MM:SS seven-segment display.
// Each digit owns a slot of DIGIT_CYCLES clocks; the first GAP_CYCLES of a
// slot are dark so the previous digit's segments never ghost onto the next
// anode. The six BCD inputs are snapshotted once per full frame, at the very
// last cycle of slot 5. This keeps a counter roll-over that happens
// mid-frame from tearing the displayed time.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   sec_units .. hr_tens   BCD digits from the time-keeping counters
//   colon_en     lights the decimal points after the minutes and hours digits
//   blink_mask   bit i makes digit i blink (time-set indication), sampled live
//   an[5:0]      digit enables, active-low, an[0]=sec_units .. an[5]=hr_tens
//   seg[6:0]     segments gfedcba, active-low
//   dp           decimal point, active-low
//   frame_start  one-cycle pulse when a freshly captured snapshot goes live

module clock_display_scan #(
    parameter int DIGIT_CYCLES  = 50000,
    parameter int GAP_CYCLES    = 500,
    parameter int BLINK_FRAMES  = 64,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_units,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] hr_units,
    input  logic [3:0] hr_tens,
    input  logic       colon_en,
    input  logic [5:0] blink_mask,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int TICK_W  = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_GAP   = TICK_W'(GAP_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]         IDX_LAST   = 3'd5;

    localparam logic [5:0] AN_OFF  = 6'b111111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // BCD to active-low gfedcba; non-decimal codes show a dash so a corrupt
    // counter value is visible rather than silently mis-rendered.
    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    // Sequencing state
    logic [TICK_W-1:0]  tick;
    logic [2:0]         idx;

    // Frame buffer: the values actually on the display for the current frame
    logic [3:0]         snap_sec_units;
    logic [3:0]         snap_sec_tens;
    logic [3:0]         snap_min_units;
    logic [3:0]         snap_min_tens;
    logic [3:0]         snap_hr_units;
    logic [3:0]         snap_hr_tens;

    // Blink timing, advanced once per completed frame
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Combinational view of the current slot
    logic               slot_end;
    logic               frame_end;
    logic [3:0]         cur_value;
    logic               cur_blink;
    logic               in_gap;
    logic               lead_blank;
    logic               digit_on;
    logic               colon_slot;
    logic [5:0]         an_next;
    logic [6:0]         seg_next;
    logic               dp_next;

    assign slot_end  = (tick == TICK_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_comb begin
        cur_value = 4'd0;
        cur_blink = 1'b0;
        case (idx)
            3'd0: begin cur_value = snap_sec_units; cur_blink = blink_mask[0]; end
            3'd1: begin cur_value = snap_sec_tens;  cur_blink = blink_mask[1]; end
            3'd2: begin cur_value = snap_min_units; cur_blink = blink_mask[2]; end
            3'd3: begin cur_value = snap_min_tens;  cur_blink = blink_mask[3]; end
            3'd4: begin cur_value = snap_hr_units;  cur_blink = blink_mask[4]; end
            3'd5: begin cur_value = snap_hr_tens;   cur_blink = blink_mask[5]; end
            default: begin cur_value = 4'd0;        cur_blink = 1'b0;          end
        endcase
    end

    always_comb begin
        in_gap     = (tick < TICK_GAP);
        lead_blank = (BLANK_LEADING != 0) && (idx == IDX_LAST) && (snap_hr_tens == 4'd0);
        digit_on   = !in_gap && !lead_blank && !(blink_phase && cur_blink);
        // Colon dots sit after the minutes-units and hours-units digits
        colon_slot = (idx == 3'd2) || (idx == 3'd4);

        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (digit_on) begin
            an_next  = ~(6'b000001 << idx);
            seg_next = seg_decode(cur_value);
            dp_next  = !(colon_en && colon_slot);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick           <= '0;
            idx            <= '0;
            snap_sec_units <= '0;
            snap_sec_tens  <= '0;
            snap_min_units <= '0;
            snap_min_tens  <= '0;
            snap_hr_units  <= '0;
            snap_hr_tens   <= '0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            an             <= AN_OFF;
            seg            <= SEG_OFF;
            dp             <= 1'b1;
            frame_start    <= 1'b0;
        end else begin
            // Slot sequencing never stalls; blanking only gates the outputs
            if (slot_end) begin
                tick <= '0;
                idx  <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end else begin
                tick <= tick + 1'b1;
            end

            // Snapshot and blink bookkeeping happen together at the frame
            // boundary so a frame is rendered with one consistent state
            frame_start <= frame_end;
            if (frame_end) begin
                snap_sec_units <= sec_units;
                snap_sec_tens  <= sec_tens;
                snap_min_units <= min_units;
                snap_min_tens  <= min_tens;
                snap_hr_units  <= hr_units;
                snap_hr_tens   <= hr_tens;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            // Registered outputs: one cycle behind the tick/idx they describe
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule
